// File: rtl/marker_row_tracker.sv
// rtl/marker_row_tracker.sv - links per-row stripe centres into vertical tracks, publishes longest per frame
module marker_row_tracker #(
  parameter int X_TOL    = 8,
  parameter int MIN_ROWS = 5,
  parameter int MAX_GAP  = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        done_in,
  input  logic [10:0] coord_in,
  input  logic [10:0] nt_prob_in,
  input  logic [9:0]  vcount_in,
  input  logic        row_end_in,
  input  logic        frame_end_in,
  output logic [10:0] marker_x_out,
  output logic [9:0]  marker_y_out,
  output logic [7:0]  marker_rows_out,
  output logic        marker_found_out,
  output logic        marker_valid_out
);

  localparam logic [10:0] X_TOL_W    = 11'(X_TOL);
  localparam logic [7:0]  MIN_ROWS_W = 8'(MIN_ROWS);
  localparam logic [2:0]  MAX_GAP_W  = 3'(MAX_GAP);

  typedef enum logic [1:0] {IDLE, ROW_EVAL, FRAME_CLOSE, PUBLISH} state_t;
  state_t state, state_nxt;

  logic        cand_valid;
  logic [10:0] cand_x, cand_nt;
  logic        pend_present;
  logic [10:0] pend_x;
  logic [9:0]  pend_y;
  logic        row_pending, frame_pending;

  logic        trk_open;
  logic [10:0] trk_x;
  logic [9:0]  trk_yf, trk_yl;
  logic [7:0]  trk_rows;
  logic [2:0]  trk_gap;
  logic [10:0] best_x;
  logic [9:0]  best_yf, best_yl;
  logic [7:0]  best_rows;

  // A done_in on the row_end_in cycle still competes for the ending row.
  logic take_new;
  assign take_new = done_in && (!cand_valid || (nt_prob_in < cand_nt));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cand_valid   <= 1'b0;
      cand_x       <= '0;
      cand_nt      <= '0;
      pend_present <= 1'b0;
      pend_x       <= '0;
      pend_y       <= '0;
    end else if (row_end_in) begin
      cand_valid   <= 1'b0;
      pend_present <= cand_valid || done_in;
      pend_x       <= take_new ? coord_in : cand_x;
      pend_y       <= vcount_in;
    end else if (take_new) begin
      cand_valid <= 1'b1;
      cand_x     <= coord_in;
      cand_nt    <= nt_prob_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      row_pending   <= 1'b0;
      frame_pending <= 1'b0;
    end else begin
      if (row_end_in)                 row_pending <= 1'b1;
      else if (state == ROW_EVAL)     row_pending <= 1'b0;
      if (frame_end_in)               frame_pending <= 1'b1;
      else if (state == FRAME_CLOSE)  frame_pending <= 1'b0;
    end
  end

  // Raw event inputs are looked at too so that IDLE does not cost a cycle of latency.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (row_pending || row_end_in)          state_nxt = ROW_EVAL;
        else if (frame_pending || frame_end_in) state_nxt = FRAME_CLOSE;
      end
      ROW_EVAL:    state_nxt = (frame_pending || frame_end_in) ? FRAME_CLOSE : IDLE;
      FRAME_CLOSE: state_nxt = PUBLISH;
      PUBLISH:     state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  logic [10:0] x_diff;
  logic        x_match;
  logic [2:0]  gap_inc;
  logic        gap_over;
  logic        close_now, close_qual;
  logic [10:0] fin_x;
  logic [9:0]  fin_yf, fin_yl;
  logic [7:0]  fin_rows;
  logic [10:0] y_sum;

  assign x_diff   = (pend_x >= trk_x) ? (pend_x - trk_x) : (trk_x - pend_x);
  assign x_match  = x_diff <= X_TOL_W;
  assign gap_inc  = (trk_gap == 3'd7) ? 3'd7 : trk_gap + 3'd1;
  assign gap_over = gap_inc > MAX_GAP_W;

  always_comb begin
    close_now = 1'b0;
    if (trk_open) begin
      if (state == ROW_EVAL)         close_now = pend_present ? !x_match : gap_over;
      else if (state == FRAME_CLOSE) close_now = 1'b1;
    end
  end

  // Strictly longer wins, so the earliest of equal-length tracks is kept.
  assign close_qual = close_now && (trk_rows >= MIN_ROWS_W) && (trk_rows > best_rows);
  assign fin_x    = close_qual ? trk_x    : best_x;
  assign fin_yf   = close_qual ? trk_yf   : best_yf;
  assign fin_yl   = close_qual ? trk_yl   : best_yl;
  assign fin_rows = close_qual ? trk_rows : best_rows;
  assign y_sum    = {1'b0, fin_yf} + {1'b0, fin_yl};

  always_ff @(posedge clk_in) begin
    if (rst_in || state == PUBLISH) begin
      trk_open  <= 1'b0;
      trk_x     <= '0;
      trk_yf    <= '0;
      trk_yl    <= '0;
      trk_rows  <= '0;
      trk_gap   <= '0;
      best_x    <= '0;
      best_yf   <= '0;
      best_yl   <= '0;
      best_rows <= '0;
    end else begin
      if (close_qual) begin
        best_x    <= trk_x;
        best_yf   <= trk_yf;
        best_yl   <= trk_yl;
        best_rows <= trk_rows;
      end
      if (state == ROW_EVAL) begin
        if (pend_present) begin
          if (trk_open && x_match) begin
            trk_rows <= (trk_rows == 8'hFF) ? 8'hFF : trk_rows + 8'd1;
            trk_x    <= pend_x;
            trk_yl   <= pend_y;
            trk_gap  <= '0;
          end else begin
            trk_open <= 1'b1;
            trk_x    <= pend_x;
            trk_yf   <= pend_y;
            trk_yl   <= pend_y;
            trk_rows <= 8'd1;
            trk_gap  <= '0;
          end
        end else if (trk_open) begin
          trk_gap <= gap_inc;
          if (gap_over) trk_open <= 1'b0;
        end
      end else if (state == FRAME_CLOSE) begin
        trk_open <= 1'b0;
      end
    end
  end

  // Results are registered at the end of FRAME_CLOSE, so they appear together with the PUBLISH strobe.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      marker_x_out     <= '0;
      marker_y_out     <= '0;
      marker_rows_out  <= '0;
      marker_found_out <= 1'b0;
      marker_valid_out <= 1'b0;
    end else begin
      marker_valid_out <= (state == FRAME_CLOSE);
      if (state == FRAME_CLOSE) begin
        marker_found_out <= (fin_rows != 8'd0);
        marker_x_out     <= (fin_rows != 8'd0) ? fin_x : 11'd0;
        marker_y_out     <= (fin_rows != 8'd0) ? y_sum[10:1] : 10'd0;
        marker_rows_out  <= fin_rows;
      end
    end
  end

endmodule

// File: tb/tb_marker_row_tracker.sv
// tb/tb_marker_row_tracker.sv - randomized and directed checks of marker_row_tracker against a frame-level model
module tb_marker_row_tracker;

  localparam int X_TOL = 8, MIN_ROWS = 5, MAX_GAP = 2;

  logic        clk_in = 1'b0;
  logic        rst_in, done_in, row_end_in, frame_end_in;
  logic [10:0] coord_in, nt_prob_in;
  logic [9:0]  vcount_in;
  logic [10:0] marker_x_out;
  logic [9:0]  marker_y_out;
  logic [7:0]  marker_rows_out;
  logic        marker_found_out, marker_valid_out;

  marker_row_tracker #(.X_TOL(X_TOL), .MIN_ROWS(MIN_ROWS), .MAX_GAP(MAX_GAP)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .done_in(done_in), .coord_in(coord_in),
    .nt_prob_in(nt_prob_in), .vcount_in(vcount_in), .row_end_in(row_end_in),
    .frame_end_in(frame_end_in), .marker_x_out(marker_x_out), .marker_y_out(marker_y_out),
    .marker_rows_out(marker_rows_out), .marker_found_out(marker_found_out),
    .marker_valid_out(marker_valid_out)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0, n_bad = 0;
  int nd[64];
  int dc[64][2];
  int dn[64][2];
  int fy;
  bit late2;

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_in;
    done_in = 0; row_end_in = 0; frame_end_in = 0;
  endtask

  task automatic fill(input int n, input int y0, input int x0, input int step);
    fy = y0;
    late2 = 0;
    for (int r = 0; r < n; r++) begin
      nd[r] = 1; dc[r][0] = x0 + step * r; dn[r][0] = 5;
    end
  endtask

  // 8 cycles per row: first done at cycle 2, second at 4 (or with row_end at 7 when late2).
  task automatic drive_rows(input int n, input bit coinc);
    for (int r = 0; r < n; r++) begin
      vcount_in = 10'(fy + r);
      for (int c = 0; c < 8; c++) begin
        clear_in;
        if (c == 2 && nd[r] >= 1) begin
          done_in = 1; coord_in = 11'(dc[r][0]); nt_prob_in = 11'(dn[r][0]);
        end
        if (c == (late2 ? 7 : 4) && nd[r] >= 2) begin
          done_in = 1; coord_in = 11'(dc[r][1]); nt_prob_in = 11'(dn[r][1]);
        end
        if (c == 7) row_end_in = 1;
        if (c == 7 && coinc && r == n - 1) frame_end_in = 1;
        else tick;
      end
    end
  endtask

  task automatic run_frame(input int n, input bit coinc, output int lat, output logic [29:0] obs);
    drive_rows(n, coinc);
    if (!coinc) begin
      clear_in; tick; tick; tick;
      frame_end_in = 1;
    end
    lat = -1;
    obs = '0;
    for (int k = 1; k <= 10; k++) begin
      tick;
      clear_in;
      if (marker_valid_out) begin
        lat = k;
        obs = {marker_found_out, marker_x_out, marker_y_out, marker_rows_out};
        break;
      end
    end
    if (lat > 0) begin
      tick;
      if (marker_valid_out) lat += 100;
    end
  endtask

  // Frame-level reference: pick the best candidate per row, split rows into tracks, keep first longest.
  task automatic model(input int n, output logic [29:0] exp);
    int open = 0, tx = 0, yf = 0, yl = 0, rows = 0, gap = 0;
    int bx = 0, byf = 0, byl = 0, brows = 0;
    for (int r = 0; r <= n; r++) begin
      bit cl = 0, op = 0;
      int cx = 0;
      bit has = (r < n) && nd[r] > 0;
      if (r < n) begin
        cx = dc[r][0];
        if (nd[r] == 2 && dn[r][1] < dn[r][0]) cx = dc[r][1];
      end
      if (r == n) cl = open != 0;
      else if (has) begin
        if (open != 0 && cx - tx <= X_TOL && tx - cx <= X_TOL) begin
          rows = (rows < 255) ? rows + 1 : 255; tx = cx; yl = fy + r; gap = 0;
        end else begin
          cl = open != 0; op = 1;
        end
      end else if (open != 0) begin
        gap++;
        if (gap > MAX_GAP) cl = 1;
      end
      if (cl && rows >= MIN_ROWS && rows > brows) begin
        bx = tx; byf = yf; byl = yl; brows = rows;
      end
      if (cl) open = 0;
      if (op) begin
        open = 1; tx = cx; yf = fy + r; yl = fy + r; rows = 1; gap = 0;
      end
    end
    exp = (brows > 0) ? {1'b1, 11'(bx), 10'((byf + byl) / 2), 8'(brows)} : 30'd0;
  endtask

  task automatic test_reset;
    rst_in = 1; clear_in; coord_in = 0; nt_prob_in = 0; vcount_in = 0;
    tick; tick; tick;
    rst_in = 0;
    tick;
    n_cmp += 5;
    if (marker_valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", marker_valid_out); end
    if (marker_found_out !== 1'b0) begin n_bad++; $display("FAIL reset_found: got %b want 0", marker_found_out); end
    if (marker_x_out !== 11'd0) begin n_bad++; $display("FAIL reset_x: got %0d want 0", marker_x_out); end
    if (marker_y_out !== 10'd0) begin n_bad++; $display("FAIL reset_y: got %0d want 0", marker_y_out); end
    if (marker_rows_out !== 8'd0) begin n_bad++; $display("FAIL reset_rows: got %0d want 0", marker_rows_out); end
  endtask

  task automatic test_basic;
    int lat; logic [29:0] obs;
    fill(10, 100, 320, 0);
    run_frame(10, 0, lat, obs);
    n_cmp += 2;
    if (lat !== 2) begin n_bad++; $display("FAIL basic_latency: got %0d want 2", lat); end
    if (obs !== {1'b1, 11'd320, 10'd104, 8'd10}) begin n_bad++; $display("FAIL basic_result: got %h want %h", obs, {1'b1, 11'd320, 10'd104, 8'd10}); end
    fill(4, 100, 320, 0);
    run_frame(4, 0, lat, obs);
    n_cmp += 2;
    if (lat !== 2) begin n_bad++; $display("FAIL short_latency: got %0d want 2", lat); end
    if (obs !== 30'd0) begin n_bad++; $display("FAIL short_result: got %h want 0", obs); end
  endtask

  task automatic test_gap;
    int lat; logic [29:0] obs;
    fill(21, 50, 200, 0);
    for (int r = 8; r < 11; r++) nd[r] = 0;
    for (int r = 11; r < 21; r++) dc[r][0] = 203;
    run_frame(21, 0, lat, obs);
    n_cmp += 1;
    if (obs !== {1'b1, 11'd203, 10'd65, 8'd10}) begin n_bad++; $display("FAIL gap_result: got %h want %h", obs, {1'b1, 11'd203, 10'd65, 8'd10}); end
  endtask

  task automatic test_two_done;
    int lat; logic [29:0] obs;
    logic [29:0] want [3];
    want[0] = {1'b1, 11'd150, 10'd14, 8'd10};
    want[1] = {1'b1, 11'd400, 10'd14, 8'd10};
    want[2] = {1'b1, 11'd150, 10'd14, 8'd10};
    for (int v = 0; v < 3; v++) begin
      fill(10, 10, 400, 0);
      for (int r = 0; r < 10; r++) begin
        nd[r] = 2; dn[r][0] = (v == 1) ? 12 : 30; dc[r][1] = 150; dn[r][1] = 12;
      end
      late2 = (v == 2);
      run_frame(10, 0, lat, obs);
      n_cmp += 1;
      if (obs !== want[v]) begin n_bad++; $display("FAIL two_done_%0d: got %h want %h", v, obs, want[v]); end
    end
    late2 = 0;
  endtask

  task automatic test_drift;
    int lat; logic [29:0] obs;
    fill(6, 300, 100, 8);
    run_frame(6, 0, lat, obs);
    n_cmp += 1;
    if (obs !== {1'b1, 11'd140, 10'd302, 8'd6}) begin n_bad++; $display("FAIL drift8: got %h want %h", obs, {1'b1, 11'd140, 10'd302, 8'd6}); end
    fill(6, 300, 100, 9);
    run_frame(6, 0, lat, obs);
    n_cmp += 1;
    if (obs !== 30'd0) begin n_bad++; $display("FAIL drift9: got %h want 0", obs); end
  endtask

  task automatic test_reset_mid;
    int lat; logic [29:0] obs;
    fill(5, 100, 50, 0);
    drive_rows(5, 0);
    vcount_in = 10'd105;
    clear_in; tick;
    done_in = 1; coord_in = 11'd50; nt_prob_in = 11'd5; tick;
    clear_in; tick;
    rst_in = 1; tick;
    rst_in = 0;
    n_cmp += 1;
    if ({marker_found_out, marker_x_out, marker_y_out, marker_rows_out, marker_valid_out} !== 31'd0) begin
      n_bad++; $display("FAIL mid_reset_outputs: got %h want 0", {marker_found_out, marker_x_out, marker_y_out, marker_rows_out});
    end
    fill(7, 200, 50, 0);
    run_frame(7, 1, lat, obs);
    n_cmp += 2;
    if (lat !== 3) begin n_bad++; $display("FAIL coinc_latency: got %0d want 3", lat); end
    if (obs !== {1'b1, 11'd50, 10'd203, 8'd7}) begin n_bad++; $display("FAIL mid_reset_result: got %h want %h", obs, {1'b1, 11'd50, 10'd203, 8'd7}); end
  endtask

  task automatic test_random;
    int lat, n, base, p; bit coinc; logic [29:0] obs, exp;
    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(20, 48);
      fy = $urandom_range(0, 900);
      base = $urandom_range(40, 1900);
      late2 = $urandom_range(0, 1);
      coinc = $urandom_range(0, 1);
      for (int r = 0; r < n; r++) begin
        p = $urandom_range(0, 9);
        nd[r] = (p < 2) ? 0 : (p < 7) ? 1 : 2;
        if ($urandom_range(0, 11) == 0) base = $urandom_range(40, 1900);
        base = base + $urandom_range(0, 6) - 3;
        for (int k = 0; k < 2; k++) begin
          dc[r][k] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2047) : base + $urandom_range(0, 18) - 9;
          dn[r][k] = $urandom_range(0, 15);
        end
      end
      model(n, exp);
      run_frame(n, coinc, lat, obs);
      n_cmp += 2;
      if (lat !== (coinc ? 3 : 2)) begin n_bad++; $display("FAIL rand%0d_latency: got %0d want %0d", f, lat, coinc ? 3 : 2); end
      if (obs !== exp) begin n_bad++; $display("FAIL rand%0d_result: got %h want %h", f, obs, exp); end
    end
    late2 = 0;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_gap;
    test_two_done;
    test_drift;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/marker_row_tracker.md
Name: marker_row_tracker

Overview:
- Sits directly downstream of the per-row stripe detector in the marker_detect pipeline. It consumes the detector's per-row centre reports (done/coord/not-target probability).
- It links candidates that repeat at roughly the same column over consecutive rows into vertical tracks.
- At end of frame it publishes one marker centre (x, y): the longest qualifying track.
- Its output feeds the downstream position/overlay logic.

Parameters:
- X_TOL, 8, max |coord difference| between consecutive rows for the same track (pixels).
- MIN_ROWS, 5, minimum track length (rows) for a track to qualify as a marker.
- MAX_GAP, 2, max consecutive rows with no matching candidate before the open track closes.

Ports:
- clk_in  input  1  pixel clock
- rst_in  input  1  synchronous active-high reset
- done_in  input  1  upstream pulse: a full target band pattern was completed on this row
- coord_in  input  11  upstream hcount of the target centre; valid with done_in
- nt_prob_in  input  11  upstream not-target score (lower is better); valid with done_in
- vcount_in  input  10  current row number
- row_end_in  input  1  one-cycle pulse on the last pixel of each row
- frame_end_in  input  1  one-cycle pulse after the last row of a frame
- marker_x_out  output  11  published marker centre column
- marker_y_out  output  10  published marker centre row
- marker_rows_out  output  8  length in rows of the published track
- marker_found_out  output  1  published frame contained a qualifying track
- marker_valid_out  output  1  one-cycle strobe: the outputs above were updated

Behaviour:
- Reset, synchronous, rst_in high at a clock edge:
  - All outputs go to 0.
  - Row candidate, open track, best track, pending row and pending frame flags are cleared. FSM goes to IDLE.
  - Reset mid-frame discards all partial state. The next frame_end_in publishes only what was seen after reset.
- Row candidate accumulator, active every cycle including during evaluation states:
  - On done_in, if no candidate exists yet or nt_prob_in is strictly less than the stored score, store (coord_in, nt_prob_in). Ties keep the earlier candidate.
  - A done_in coincident with row_end_in belongs to the ending row.
- On row_end_in:
  - Snapshot the candidate (present flag, x) and vcount_in into the pending row registers.
  - Clear the accumulator for the next row.
  - Set row_pending.
- FSM states: IDLE, ROW_EVAL, FRAME_CLOSE, PUBLISH.
  - IDLE: if row_pending, go to ROW_EVAL. Else if frame_pending, go to FRAME_CLOSE. Row evaluation has priority.
  - ROW_EVAL (1 cycle): clear row_pending, then:
    - Candidate present, no open track: open a track with x=cand_x, y_first=y_last=row_y, rows=1, gap=0.
    - Candidate present, open track, |cand_x - track_x| <= X_TOL: rows+1 (saturate at 255), track_x <= cand_x, y_last <= row_y, gap <= 0.
    - Candidate present, open track, mismatch: close the current track, then open a new track from the candidate in the same cycle.
    - No candidate, open track: gap+1. If the new gap > MAX_GAP, close the track.
    - No candidate, no track: no action.
    - Return to IDLE.
  - Close a track:
    - Qualifies if rows >= MIN_ROWS and rows > best_rows (strict). Equal lengths keep the earlier track.
    - If qualifying, copy into best: x, y_first, y_last, rows.
    - The track becomes not-open.
  - FRAME_CLOSE (1 cycle): clear frame_pending, close any open track, go to PUBLISH.
  - PUBLISH (1 cycle):
    - marker_valid_out = 1.
    - If a best track exists: marker_found_out=1, marker_x_out=best_x, marker_y_out=(y_first+y_last)>>1 (11-bit sum, no overflow), marker_rows_out=best_rows.
    - If no best track: marker_found_out=0, and x/y/rows are driven to 0.
    - Clear best and track state, return to IDLE.
- Output timing:
  - Data outputs hold their published values until the next PUBLISH.
  - marker_valid_out is high for exactly one cycle.
- Latency:
  - frame_end_in alone at cycle T: marker_valid_out high in cycle T+2.
  - frame_end_in coincident with row_end_in at T: the row is evaluated first, and marker_valid_out is high in cycle T+3.
- Event capture:
  - row_end_in / frame_end_in arriving in a non-IDLE state are latched through the pending flags; none is lost.
  - Upstream guarantees at least 4 cycles between row_end_in pulses.
- Widths and arithmetic:
  - |a-b| is computed on 11 bits via compare-and-subtract, with no wrap.
  - gap is a 3-bit saturating counter.

Test Plan:
- Rows 100..109, done_in with coord_in=320 each row, then frame_end_in -> valid strobe at T+2; found=1, x=320, y=104, rows=10.
- Same, but rows 100..103 only (4 rows) -> found=0, x=0, y=0, rows=0, valid=1.
- Rows 50..57 coord 200, 3 empty rows, rows 61..70 coord 203 -> first track closes at the third empty row (gap 3 > 2). Published: x=203, y=65, rows=10.
- Two done_in in one row, (400, nt=30) then (150, nt=12), for rows 10..19 -> track at x=150, rows=10. Also repeat with equal nt: the first candidate is kept.
- Drift of +8 per row from x=100 over 6 rows -> single track, x=140, rows=6. Drift of +9 per row -> no qualifying track, found=0.
- rst_in asserted mid-track at row 105, then rows 200..206 at x=50 -> published rows=7, y=203. Also: row_end_in and frame_end_in coincident -> last row included, valid at T+3.
